// File: rtl/nv_nvdla_cdma_csb_adapter.sv
// -----------------------------------------------------------------------------
// nv_nvdla_cdma_csb_adapter
//
// Purpose:
//   Bridges the CSB request/response channel onto a simple register-file port
//   for the CDMA register window at byte addresses 0x5000..0x5FFF.
//   The pipeline has two fixed stages:
//     stage 1: the accepted request drives reg_offset / reg_wr_data /
//              reg_wr_en, and the register file returns reg_rd_data.
//     stage 2: the registered response (read data or write-ack) is presented
//              on cdma2csb_resp_* for one cycle.
//   The adapter never back-pressures. It accepts one request per cycle and
//   returns responses in request order.
//
// Ports:
//   nvdla_core_clk       in   1   clock, rising edge
//   nvdla_core_rstn      in   1   asynchronous active-low reset
//   csb2cdma_req_pvld    in   1   request valid
//   csb2cdma_req_prdy    out  1   request ready (1 after reset release)
//   csb2cdma_req_pd      in  63   {level,wrbe,srcpriv,nposted,write,wdat,addr}
//   cdma2csb_resp_valid  out  1   one-cycle response strobe
//   cdma2csb_resp_pd     out 34   {type,error,rdata}
//   reg_offset           out 12   byte offset into the register file
//   reg_wr_data          out 32   register write data
//   reg_wr_en            out  1   one-cycle register write strobe
//   reg_rd_data          in  32   combinational read data for reg_offset
// -----------------------------------------------------------------------------
module nv_nvdla_cdma_csb_adapter (
   input  logic        nvdla_core_clk,
   input  logic        nvdla_core_rstn,
   input  logic        csb2cdma_req_pvld,
   output logic        csb2cdma_req_prdy,
   input  logic [62:0] csb2cdma_req_pd,
   output logic        cdma2csb_resp_valid,
   output logic [33:0] cdma2csb_resp_pd,
   output logic [11:0] reg_offset,
   output logic [31:0] reg_wr_data,
   output logic        reg_wr_en,
   input  logic [31:0] reg_rd_data
);

   // Upper 12 bits of the 24-bit byte address that select the CDMA window.
   localparam logic [11:0] WINDOW_PAGE = 12'h005;

   // Request field decode
   logic [21:0] w_req_addr;
   logic [31:0] w_req_wdat;
   logic        w_req_write;
   logic        w_req_nposted;
   logic        w_accept;
   logic        w_req_in_range;
   // wrbe, srcpriv and level are not used: every write is a full word.
   logic        w_unused_fields;

   assign w_req_addr      = csb2cdma_req_pd[21:0];
   assign w_req_wdat      = csb2cdma_req_pd[53:22];
   assign w_req_write     = csb2cdma_req_pd[54];
   assign w_req_nposted   = csb2cdma_req_pd[55];
   assign w_unused_fields = ^csb2cdma_req_pd[62:56];

   // Registers
   logic        r_req_prdy;
   logic        r_req_vld_s1;
   logic        r_s1_write;
   logic        r_s1_nposted;
   logic        r_s1_in_range;
   logic [11:0] r_reg_offset;
   logic [31:0] r_reg_wr_data;
   logic        r_reg_wr_en;
   logic        r_resp_valid;
   logic [33:0] r_resp_pd;

   // Stage-2 next values
   logic        w_resp_fire;
   logic [33:0] w_resp_pd;

   // Byte address = {word address, 2'b00}, so byte[23:12] is word[21:10].
   function automatic logic in_window(input logic [21:0] word_addr);
      in_window = (word_addr[21:10] == WINDOW_PAGE);
   endfunction

   assign w_accept       = csb2cdma_req_pvld & r_req_prdy;
   assign w_req_in_range = in_window(w_req_addr);

   // Ready comes up on the first clock edge after reset release and stays up.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_req_prdy <= 1'b0;
      end else begin
         r_req_prdy <= 1'b1;
      end
   end

   // Stage 1: capture the accepted request and drive the register-file port.
   // Offset and write data hold their last value while stage 1 is idle.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_req_vld_s1  <= 1'b0;
         r_s1_write    <= 1'b0;
         r_s1_nposted  <= 1'b0;
         r_s1_in_range <= 1'b0;
         r_reg_offset  <= 12'h000;
         r_reg_wr_data <= 32'h0000_0000;
         r_reg_wr_en   <= 1'b0;
      end else if (w_accept) begin
         r_req_vld_s1  <= 1'b1;
         r_s1_write    <= w_req_write;
         r_s1_nposted  <= w_req_nposted;
         r_s1_in_range <= w_req_in_range;
         r_reg_offset  <= {w_req_addr[9:0], 2'b00};
         r_reg_wr_data <= w_req_wdat;
         r_reg_wr_en   <= w_req_write & w_req_in_range;
      end else begin
         r_req_vld_s1  <= 1'b0;
         r_reg_wr_en   <= 1'b0;
      end
   end

   // Build the response from stage 1. Reads sample reg_rd_data here. A write
   // accepted one cycle later only strobes in the following cycle, so the read
   // sees the register state before that write.
   always_comb begin
      w_resp_fire = 1'b0;
      w_resp_pd   = 34'h0_0000_0000;
      if (r_req_vld_s1) begin
         if (r_s1_write) begin
            w_resp_fire = r_s1_nposted;
            w_resp_pd   = {1'b1, 1'b0, 32'h0000_0000};
         end else begin
            w_resp_fire = 1'b1;
            if (r_s1_in_range) begin
               w_resp_pd = {1'b0, 1'b0, reg_rd_data};
            end else begin
               w_resp_pd = {1'b0, 1'b0, 32'h0000_0000};
            end
         end
      end else begin
         w_resp_fire = 1'b0;
         w_resp_pd   = 34'h0_0000_0000;
      end
   end

   // Stage 2: one-cycle response strobe; the payload holds until the next response.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_resp_valid <= 1'b0;
         r_resp_pd    <= 34'h0_0000_0000;
      end else if (w_resp_fire) begin
         r_resp_valid <= 1'b1;
         r_resp_pd    <= w_resp_pd;
      end else begin
         r_resp_valid <= 1'b0;
      end
   end

   assign csb2cdma_req_prdy   = r_req_prdy;
   assign reg_offset          = r_reg_offset;
   assign reg_wr_data         = r_reg_wr_data;
   assign reg_wr_en           = r_reg_wr_en;
   assign cdma2csb_resp_valid = r_resp_valid;
   assign cdma2csb_resp_pd    = r_resp_pd;

endmodule

// File: tb/tb_nv_nvdla_cdma_csb_adapter.sv
// -----------------------------------------------------------------------------
// tb_nv_nvdla_cdma_csb_adapter
//
// Purpose:
//   Directed bench for nv_nvdla_cdma_csb_adapter. A small word-array register
//   file answers reg_offset combinationally and absorbs reg_wr_en writes.
//   The bench drives inputs on the falling edge and samples outputs on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_nv_nvdla_cdma_csb_adapter;

   logic        clk;
   logic        rst_n;
   logic        req_pvld;
   logic        req_prdy;
   logic [62:0] req_pd;
   logic        resp_valid;
   logic [33:0] resp_pd;
   logic [11:0] reg_offset;
   logic [31:0] reg_wr_data;
   logic        reg_wr_en;
   logic [31:0] reg_rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   // Register-file model, preloadable through the preset port.
   logic [31:0] mem [0:1023];
   logic        preset_en;
   logic [9:0]  preset_idx;
   logic [31:0] preset_val;

   nv_nvdla_cdma_csb_adapter dut (
      .nvdla_core_clk      (clk),
      .nvdla_core_rstn     (rst_n),
      .csb2cdma_req_pvld   (req_pvld),
      .csb2cdma_req_prdy   (req_prdy),
      .csb2cdma_req_pd     (req_pd),
      .cdma2csb_resp_valid (resp_valid),
      .cdma2csb_resp_pd    (resp_pd),
      .reg_offset          (reg_offset),
      .reg_wr_data         (reg_wr_data),
      .reg_wr_en           (reg_wr_en),
      .reg_rd_data         (reg_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign reg_rd_data = mem[reg_offset[11:2]];

   // Register file write port: DUT strobe first, otherwise bench preload.
   always @(posedge clk) begin
      if (reg_wr_en) mem[reg_offset[11:2]] <= reg_wr_data;
      else if (preset_en) mem[preset_idx] <= preset_val;
   end

   function automatic logic [62:0] pack(input logic [21:0] addr, input logic [31:0] wdat,
                                        input logic write, input logic nposted,
                                        input logic srcpriv, input logic [3:0] wrbe,
                                        input logic [1:0] level);
      pack = {level, wrbe, srcpriv, nposted, write, wdat, addr};
   endfunction

   task automatic preset(input logic [9:0] idx, input logic [31:0] val);
      @(negedge clk);
      preset_en = 1'b1; preset_idx = idx; preset_val = val;
      @(negedge clk);
      preset_en = 1'b0;
   endtask

   // Present one request at the next falling edge; it is accepted on the following rising edge.
   task automatic drive_req(input logic [21:0] addr, input logic [31:0] wdat,
                            input logic write, input logic nposted);
      @(negedge clk);
      req_pvld = 1'b1;
      req_pd   = pack(addr, wdat, write, nposted, 1'b0, 4'hF, 2'b00);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req_pvld = 1'b0; req_pd = 63'h0;
      preset_en = 1'b0; preset_idx = 10'h0; preset_val = 32'h0;
      repeat (3) @(negedge clk);
      n_checks++; if (req_prdy !== 1'b0) begin n_fail++; $display("FAIL rst_prdy: got %b expected 0", req_prdy); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
      n_checks++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b expected 0", reg_wr_en); end
      n_checks++; if (reg_offset !== 12'h000) begin n_fail++; $display("FAIL rst_offset: got %h expected 000", reg_offset); end
      n_checks++; if (reg_wr_data !== 32'h0) begin n_fail++; $display("FAIL rst_wr_data: got %h expected 0", reg_wr_data); end
      n_checks++; if (resp_pd !== 34'h0) begin n_fail++; $display("FAIL rst_resp_pd: got %h expected 0", resp_pd); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (req_prdy !== 1'b0) begin n_fail++; $display("FAIL rel_prdy_before_edge: got %b expected 0", req_prdy); end
      @(negedge clk);
      n_checks++; if (req_prdy !== 1'b1) begin n_fail++; $display("FAIL rel_prdy_after_edge: got %b expected 1", req_prdy); end
   endtask

   task automatic test_nonposted_write;
      @(negedge clk);
      req_pvld = 1'b1;
      // wrbe=0, srcpriv=1, level=3 must not matter: still a full write.
      req_pd = pack(22'h1402, 32'h0005_000A, 1'b1, 1'b1, 1'b1, 4'h0, 2'b11);
      @(negedge clk); req_pvld = 1'b0;
      n_checks++; if (reg_offset !== 12'h008) begin n_fail++; $display("FAIL npw_offset: got %h expected 008", reg_offset); end
      n_checks++; if (reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL npw_wr_en: got %b expected 1", reg_wr_en); end
      n_checks++; if (reg_wr_data !== 32'h0005_000A) begin n_fail++; $display("FAIL npw_wr_data: got %h expected 0005000a", reg_wr_data); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL npw_resp_early: got %b expected 0", resp_valid); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL npw_resp_valid: got %b expected 1", resp_valid); end
      n_checks++; if (resp_pd !== 34'h2_0000_0000) begin n_fail++; $display("FAIL npw_resp_pd: got %h expected 200000000", resp_pd); end
      n_checks++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL npw_wr_en_single: got %b expected 0", reg_wr_en); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL npw_resp_single: got %b expected 0", resp_valid); end
   endtask

   task automatic test_read;
      preset(10'd1, 32'h0001_0000);
      drive_req(22'h1401, 32'h0, 1'b0, 1'b0);
      @(negedge clk); req_pvld = 1'b0;
      n_checks++; if (reg_offset !== 12'h004) begin n_fail++; $display("FAIL rd_offset: got %h expected 004", reg_offset); end
      n_checks++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL rd_wr_en: got %b expected 0", reg_wr_en); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_resp_valid: got %b expected 1", resp_valid); end
      n_checks++; if (resp_pd !== 34'h0_0001_0000) begin n_fail++; $display("FAIL rd_resp_pd: got %h expected 000010000", resp_pd); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_resp_single: got %b expected 0", resp_valid); end
      n_checks++; if (resp_pd !== 34'h0_0001_0000) begin n_fail++; $display("FAIL rd_resp_hold: got %h expected 000010000", resp_pd); end
   endtask

   task automatic test_posted_write;
      drive_req(22'h1402, 32'h1234_5678, 1'b1, 1'b0);
      @(negedge clk); req_pvld = 1'b0;
      n_checks++; if (reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL pw_wr_en: got %b expected 1", reg_wr_en); end
      n_checks++; if (reg_wr_data !== 32'h1234_5678) begin n_fail++; $display("FAIL pw_wr_data: got %h expected 12345678", reg_wr_data); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL pw_no_resp[%0d]: got %b expected 0", i, resp_valid); end
      end
      n_checks++; if (resp_pd !== 34'h0_0001_0000) begin n_fail++; $display("FAIL pw_pd_hold: got %h expected 000010000", resp_pd); end
      n_checks++; if (mem[2] !== 32'h1234_5678) begin n_fail++; $display("FAIL pw_mem: got %h expected 12345678", mem[2]); end
   endtask

   task automatic test_out_of_range;
      preset(10'd0, 32'hDEAD_BEEF);
      preset(10'd1023, 32'h0BAD_F00D);
      // Read at byte 0x0: register file would return nonzero, response must be 0.
      drive_req(22'h0000, 32'h0, 1'b0, 1'b0);
      @(negedge clk); req_pvld = 1'b0;
      n_checks++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL oor_rd_wr_en: got %b expected 0", reg_wr_en); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL oor_rd_valid: got %b expected 1", resp_valid); end
      n_checks++; if (resp_pd !== 34'h0) begin n_fail++; $display("FAIL oor_rd_pd: got %h expected 0", resp_pd); end
      // Non-posted write at byte 0x0: ack but no strobe.
      drive_req(22'h0000, 32'h55AA_55AA, 1'b1, 1'b1);
      @(negedge clk); req_pvld = 1'b0;
      n_checks++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL oor_wr_wr_en: got %b expected 0", reg_wr_en); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL oor_wr_valid: got %b expected 1", resp_valid); end
      n_checks++; if (resp_pd !== 34'h2_0000_0000) begin n_fail++; $display("FAIL oor_wr_pd: got %h expected 200000000", resp_pd); end
      n_checks++; if (mem[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL oor_wr_mem: got %h expected deadbeef", mem[0]); end
      // Just above the window (byte 0x6000): out of range.
      drive_req(22'h1800, 32'h0, 1'b0, 1'b0);
      @(negedge clk); req_pvld = 1'b0;
      @(negedge clk);
      n_checks++; if (resp_pd !== 34'h0) begin n_fail++; $display("FAIL oor_above_pd: got %h expected 0", resp_pd); end
      // Last word of the window (byte 0x5FFC): in range.
      drive_req(22'h17FF, 32'h0, 1'b0, 1'b0);
      @(negedge clk); req_pvld = 1'b0;
      n_checks++; if (reg_offset !== 12'hFFC) begin n_fail++; $display("FAIL top_offset: got %h expected ffc", reg_offset); end
      @(negedge clk);
      n_checks++; if (resp_pd !== 34'h0_0BAD_F00D) begin n_fail++; $display("FAIL top_pd: got %h expected 00badf00d", resp_pd); end
   endtask

   task automatic test_back_to_back;
      preset(10'd0, 32'h1111_2222);
      drive_req(22'h1400, 32'h0, 1'b0, 1'b0);
      drive_req(22'h1400, 32'hCAFE_F00D, 1'b1, 1'b1);
      n_checks++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_rd1_wr_en: got %b expected 0", reg_wr_en); end
      drive_req(22'h1400, 32'h0, 1'b0, 1'b0);
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_r1_valid: got %b expected 1", resp_valid); end
      n_checks++; if (resp_pd !== 34'h0_1111_2222) begin n_fail++; $display("FAIL b2b_r1_pd: got %h expected 011112222", resp_pd); end
      n_checks++; if (reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_en: got %b expected 1", reg_wr_en); end
      @(negedge clk); req_pvld = 1'b0;
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_w_valid: got %b expected 1", resp_valid); end
      n_checks++; if (resp_pd !== 34'h2_0000_0000) begin n_fail++; $display("FAIL b2b_w_pd: got %h expected 200000000", resp_pd); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_r2_valid: got %b expected 1", resp_valid); end
      n_checks++; if (resp_pd !== 34'h0_CAFE_F00D) begin n_fail++; $display("FAIL b2b_r2_pd: got %h expected 0cafef00d", resp_pd); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b expected 0", resp_valid); end
   endtask

   // at_stage: 1 = reset while the read sits in stage 1, 2 = while its response is out.
   task automatic test_reset_mid(input int at_stage);
      drive_req(22'h1401, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1; req_pvld = 1'b0;
      if (at_stage == 2) begin
         @(posedge clk); #1;
         n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL mid%0d_pre_valid: got %b expected 1", at_stage, resp_valid); end
      end
      rst_n = 1'b0;
      #1;
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid%0d_valid_drop: got %b expected 0", at_stage, resp_valid); end
      n_checks++; if (req_prdy !== 1'b0) begin n_fail++; $display("FAIL mid%0d_prdy_rst: got %b expected 0", at_stage, req_prdy); end
      repeat (2) @(negedge clk);
      n_checks++; if (req_prdy !== 1'b0) begin n_fail++; $display("FAIL mid%0d_prdy_hold: got %b expected 0", at_stage, req_prdy); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (req_prdy !== 1'b0) begin n_fail++; $display("FAIL mid%0d_prdy_rel: got %b expected 0", at_stage, req_prdy); end
      @(negedge clk);
      n_checks++; if (req_prdy !== 1'b1) begin n_fail++; $display("FAIL mid%0d_prdy_up: got %b expected 1", at_stage, req_prdy); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid%0d_no_resp[%0d]: got %b expected 0", at_stage, i, resp_valid); end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset;
      test_nonposted_write;
      test_read;
      test_posted_write;
      test_out_of_range;
      test_back_to_back;
      test_reset_mid(1);
      test_reset_mid(2);
      // Pipeline still works after a mid-stream reset.
      test_read;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
